rd_port_arbiter: RTL and testbench

RD_PORT_ARBITER -- requirements
Module: rd_port_arbiter

---
 rtl/rd_arb_pkg.sv | 10 +
 rtl/rd_arb_tag_fifo.sv | 52 +++++
 rtl/rd_port_arbiter.sv | 99 +++++++++
 tb/tb_rd_port_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rd_arb_pkg.sv
// Shared definitions for the two-port read arbiter: default widths and requester id type.
package rd_arb_pkg;

  localparam int RD_ADDR_W = 8;
  localparam int RD_DATA_W = 16;

  // Requester identity: 0 = m0, 1 = m1
  typedef logic req_id_t;

endpackage

// File: rtl/rd_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each outstanding memory read, in issue order.
module rd_arb_tag_fifo
  import rd_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head_id,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  req_id_t          tags [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = tags[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Tag storage; contents are only meaningful between rd_ptr and wr_ptr so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) tags[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory read port between two requesters,
// routing each response back to the requester that issued it.
module rd_port_arbiter
  import rd_arb_pkg::*;
#(
  parameter int ADDR_W    = RD_ADDR_W,
  parameter int DATA_W    = RD_DATA_W,
  parameter int MAX_OUTST = 8
) (
  input  logic                         aclk,
  input  logic                         reset_p,
  input  logic [ADDR_W-1:0]            m0_rd_addr,
  input  logic                         m0_rd_read,
  output logic                         m0_rd_gnt,
  output logic [DATA_W-1:0]            m0_rd_data,
  output logic                         m0_rd_valid,
  input  logic [ADDR_W-1:0]            m1_rd_addr,
  input  logic                         m1_rd_read,
  output logic                         m1_rd_gnt,
  output logic [DATA_W-1:0]            m1_rd_data,
  output logic                         m1_rd_valid,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  output logic                         mem_rd_read,
  input  logic [DATA_W-1:0]            mem_rd_data,
  input  logic                         mem_rd_valid,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_unexp
);

  req_id_t last_id;
  req_id_t head_id;
  logic    full;
  logic    empty;
  logic    pop;

  // A response only consumes a tag if one is actually outstanding
  assign pop = mem_rd_valid && !empty;

  rd_arb_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (aclk),
    .rst     (reset_p),
    .push    (mem_rd_read),
    .push_id (m1_rd_gnt),
    .pop     (pop),
    .head_id (head_id),
    .count   (outst_cnt),
    .full    (full),
    .empty   (empty)
  );

  // Grant selection: single requester wins outright, contention goes to the one not granted last
  always_comb begin
    m0_rd_gnt = 1'b0;
    m1_rd_gnt = 1'b0;
    if (!reset_p && !full) begin
      if (m0_rd_read && m1_rd_read) begin
        if (last_id == 1'b1) m0_rd_gnt = 1'b1;
        else                 m1_rd_gnt = 1'b1;
      end else if (m0_rd_read) begin
        m0_rd_gnt = 1'b1;
      end else if (m1_rd_read) begin
        m1_rd_gnt = 1'b1;
      end
    end
  end

  assign mem_rd_read = m0_rd_gnt | m1_rd_gnt;
  assign mem_rd_addr = m1_rd_gnt ? m1_rd_addr : m0_rd_addr;

  // Round-robin history; reset favours m0 on first contention
  always_ff @(posedge aclk) begin
    if (reset_p)          last_id <= 1'b1;
    else if (mem_rd_read) last_id <= m1_rd_gnt;
  end

  // Response routing: one-cycle registered strobe to the owner of the popped tag, data held otherwise
  always_ff @(posedge aclk) begin
    if (reset_p) begin
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
    end else begin
      m0_rd_valid <= pop && (head_id == 1'b0);
      m1_rd_valid <= pop && (head_id == 1'b1);
      if (pop && (head_id == 1'b0)) m0_rd_data <= mem_rd_data;
      if (pop && (head_id == 1'b1)) m1_rd_data <= mem_rd_data;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge aclk) begin
    if (reset_p)                    err_unexp <= 1'b0;
    else if (mem_rd_valid && empty) err_unexp <= 1'b1;
  end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Randomized bench for rd_port_arbiter against a queue-based behavioural model of the arbiter
// and a bench-side in-order memory with random latency.
module tb_rd_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MO = 8;

  logic          aclk = 1'b0;
  logic          reset_p;
  logic [AW-1:0] m0_rd_addr, m1_rd_addr;
  logic          m0_rd_read, m1_rd_read;
  logic          m0_rd_gnt, m1_rd_gnt;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          m0_rd_valid, m1_rd_valid;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_read;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic [$clog2(MO):0] outst_cnt;
  logic          err_unexp;

  always #5 aclk = ~aclk;

  rd_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .aclk        (aclk),
    .reset_p     (reset_p),
    .m0_rd_addr  (m0_rd_addr),
    .m0_rd_read  (m0_rd_read),
    .m0_rd_gnt   (m0_rd_gnt),
    .m0_rd_data  (m0_rd_data),
    .m0_rd_valid (m0_rd_valid),
    .m1_rd_addr  (m1_rd_addr),
    .m1_rd_read  (m1_rd_read),
    .m1_rd_gnt   (m1_rd_gnt),
    .m1_rd_data  (m1_rd_data),
    .m1_rd_valid (m1_rd_valid),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_read (mem_rd_read),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .outst_cnt   (outst_cnt),
    .err_unexp   (err_unexp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  int            tagq[$];      // owners of outstanding reads, oldest first
  logic [DW-1:0] memq[$];      // data the bench memory still owes, oldest first
  int            last_win;
  bit            m_err;
  bit            e_v0, e_v1;
  logic [DW-1:0] e_d0, e_d1;
  bit            g0, g1;
  bit            done0, done1;

  initial begin
    int req_p, resp_p, spur_p, rst_p;
    int ph, id;
    reset_p      = 1'b1;
    m0_rd_read   = 1'b0;
    m1_rd_read   = 1'b0;
    m0_rd_addr   = '0;
    m1_rd_addr   = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    repeat (2) @(posedge aclk);
    last_win = 1; m_err = 0;
    e_v0 = 0; e_v1 = 0; e_d0 = '0; e_d1 = '0;
    done0 = 0; done1 = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      ph = (cyc / 400) % 6;
      case (ph)
        0: begin req_p = 90; resp_p = 60; spur_p = 0;  rst_p = 0; end
        1: begin req_p = 90; resp_p = 0;  spur_p = 0;  rst_p = 0; end
        2: begin req_p = 50; resp_p = 40; spur_p = 5;  rst_p = 0; end
        3: begin req_p = 5;  resp_p = 50; spur_p = 30; rst_p = 0; end
        4: begin req_p = 70; resp_p = 30; spur_p = 5;  rst_p = 3; end
        default: begin req_p = 80; resp_p = 90; spur_p = 2; rst_p = 1; end
      endcase

      // Registered outputs, one step after the edge
      #1;
      check_val("m0_valid", 32'(m0_rd_valid), 32'(e_v0));
      check_val("m1_valid", 32'(m1_rd_valid), 32'(e_v1));
      check_val("m0_data",  32'(m0_rd_data),  32'(e_d0));
      check_val("m1_data",  32'(m1_rd_data),  32'(e_d1));
      check_val("outst_cnt", 32'(outst_cnt),  32'(tagq.size()));
      check_val("err_unexp", 32'(err_unexp), 32'(m_err));

      // New stimulus; a request stays up with its address until granted
      reset_p = (cyc < 2) || ($urandom_range(99) < rst_p);
      if (done0) m0_rd_read = 1'b0;
      if (done1) m1_rd_read = 1'b0;
      done0 = 0; done1 = 0;
      if (!m0_rd_read) begin
        m0_rd_read = ($urandom_range(99) < req_p);
        m0_rd_addr = AW'($urandom);
      end
      if (!m1_rd_read) begin
        m1_rd_read = ($urandom_range(99) < req_p);
        m1_rd_addr = AW'($urandom);
      end
      if (memq.size() > 0) begin
        mem_rd_valid = ($urandom_range(99) < resp_p);
        mem_rd_data  = mem_rd_valid ? memq[0] : DW'($urandom);
      end else begin
        mem_rd_valid = ($urandom_range(99) < spur_p);
        mem_rd_data  = DW'($urandom);
      end

      // Expected grant from the arbitration rules
      g0 = 0; g1 = 0;
      if (!reset_p && tagq.size() < MO) begin
        if (m0_rd_read && m1_rd_read) begin
          if (last_win == 1) g0 = 1; else g1 = 1;
        end else if (m0_rd_read) g0 = 1;
        else if (m1_rd_read)     g1 = 1;
      end

      #2;
      check_val("m0_gnt",   32'(m0_rd_gnt),   32'(g0));
      check_val("m1_gnt",   32'(m1_rd_gnt),   32'(g1));
      check_val("mem_read", 32'(mem_rd_read), 32'(g0 | g1));
      check_val("mem_addr", 32'(mem_rd_addr), 32'(g1 ? m1_rd_addr : m0_rd_addr));

      // Model advance for the coming edge
      if (reset_p) begin
        tagq.delete();
        last_win = 1; m_err = 0;
        e_v0 = 0; e_v1 = 0; e_d0 = '0; e_d1 = '0;
      end else begin
        e_v0 = 0; e_v1 = 0;
        if (mem_rd_valid) begin
          if (tagq.size() > 0) begin
            id = tagq.pop_front();
            if (id == 0) begin e_v0 = 1; e_d0 = mem_rd_data; end
            else         begin e_v1 = 1; e_d1 = mem_rd_data; end
          end else begin
            m_err = 1;
          end
        end
        if (g0 || g1) begin
          tagq.push_back(g1 ? 1 : 0);
          last_win = g1 ? 1 : 0;
        end
      end
      if (mem_rd_valid && memq.size() > 0) void'(memq.pop_front());
      if (g0 || g1) memq.push_back(DW'($urandom));
      done0 = g0; done1 = g1;

      @(posedge aclk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
